mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- Memory-access stage; sits directly upstream of the write-back stage.
- Takes the executed load/store (effective address from the ALU, store data from rs2) and runs a single outstanding transaction on the data bus.
- Formats load data and produces the `read_data`, `read_valid`, `wb_mask` and `mem_stall` signals that write-back consumes.
- Stalls the pipeline until the transaction completes; flags misaligned accesses and bus errors.

Parameters:
- ADDR_W, 32, data bus address width
- XLEN, 32, data width

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- instr_valid  input  1  current instruction is valid
- is_load  input  1  instruction is a load
- is_store  input  1  instruction is a store
- funct3  input  3  size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU (stores use [1:0] only)
- addr  input  ADDR_W  effective address (ALU result)
- store_data  input  XLEN  rs2 value
- mem_stall  output  1  pipeline must hold; inputs stay stable while high
- read_valid  output  1  formatted load data valid
- read_data  output  XLEN  load data, shifted to LSB and sign/zero-extended
- wb_mask  output  XLEN  byte-size mask for unsigned loads, all-ones otherwise
- misaligned  output  1  access misaligned; no bus transaction issued
- bus_err  output  1  one-cycle pulse, bus returned error
- dbus_req_valid  output  1  request valid
- dbus_req_ready  input  1  request accepted when valid & ready
- dbus_addr  output  ADDR_W  word-aligned address ({addr[31:2],2'b00})
- dbus_we  output  1  write request
- dbus_wstrb  output  4  byte strobes
- dbus_wdata  output  XLEN  store data replicated to lanes
- dbus_resp_valid  input  1  response (read data or write ack)
- dbus_resp_err  input  1  error qualifier on response
- dbus_rdata  input  XLEN  read data

Behaviour:
- States: IDLE, REQ, RESP, DONE.
- Reset values: state=IDLE, all outputs 0, except `wb_mask` = 32'hFFFFFFFF.
- **Access detection:** in IDLE, `access = instr_valid & (is_load | is_store) & !misaligned`.
- **Misalignment:** halfword with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - `misaligned` is combinational and valid in IDLE only.
  - No request is issued, no stall is raised, state stays IDLE.
- **IDLE:** if `access`, `mem_stall`=1 (combinational) and move to REQ. On that edge, register:
  - `dbus_addr`;
  - `dbus_we = is_store`;
  - `dbus_wstrb`: SB `4'b0001<<addr[1:0]`, SH `4'b0011<<addr[1:0]`, SW `4'b1111`;
  - `dbus_wdata`: SB `{4{sd[7:0]}}`, SH `{2{sd[15:0]}}`, SW `sd`;
  - `addr[1:0]` and `funct3`.
- **REQ:**
  - `dbus_req_valid`=1, `mem_stall`=1.
  - Request fields stay stable until `dbus_req_ready`; then go to RESP.
- **RESP:**
  - `dbus_req_valid`=0, `mem_stall`=1.
  - A response never arrives in the acceptance cycle; any `dbus_resp_valid` while not in RESP is ignored.
  - On `dbus_resp_valid`, capture and format `dbus_rdata` into `read_data` and go to DONE.
  - Formatting: shift right by `8*addr[1:0]`, then sign-extend (LB/LH) or zero-extend (LBU/LHU/LW).
  - If `dbus_resp_err`: `bus_err` pulses 1 in the DONE cycle and `read_valid` stays 0.
- **DONE:**
  - `mem_stall`=0, `read_valid` = was_load & !err, `read_data` holds.
  - The pipeline advances on this edge; the next state is always IDLE, so the held instruction is never reissued.
- **Stores:** same flow; `read_valid`=0, `read_data` holds its previous value.
- **wb_mask:** LBU 32'h000000FF, LHU 32'h0000FFFF, else 32'hFFFFFFFF. Registered with `read_data`.
- **Minimum latency:** ready=1, response one cycle later → stall high 3 cycles (IDLE, REQ, RESP), DONE on the 4th.
- **Back-to-back accesses:** the next instruction is evaluated in IDLE the cycle after DONE; there is one idle cycle between transactions.
- **Reset mid-operation:** state→IDLE, `dbus_req_valid` drops the same edge. The bus is reset together, so no late response is expected; any that arrives is ignored.
- `instr_valid` dropping while in REQ/RESP has no effect; the transaction completes.

Test Plan:
- LW addr=0x100, ready=1, rdata=0xDEADBEEF next cycle → stall 3 cycles; DONE: read_valid=1, read_data=0xDEADBEEF, wb_mask=0xFFFFFFFF.
- LB addr=0x103, rdata=0x80FFFFFF → read_data=0xFFFFFF80; LBU same → read_data=0x00000080, wb_mask=0x000000FF.
- SH addr=0x202, store_data=0x1234ABCD, ready delayed 3 cycles → req_valid held 4 cycles with fields stable, wstrb=4'b1100, wdata=0xABCDABCD; DONE read_valid=0.
- LW addr=0x101 → misaligned=1, req_valid never asserts, mem_stall=0.
- LH with resp_err=1 → bus_err pulse 1 cycle in DONE, read_valid=0; next access proceeds normally.
- rst asserted in RESP → next cycle IDLE, req_valid=0, stall=0; a stray resp_valid afterwards produces no read_valid.

Source files
------------

// File: rtl/mem_access.sv
// Memory-access stage: runs one outstanding load/store on the data bus,
// stalls the pipeline until it completes and formats load data for write-back.
module mem_access #(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic              is_load,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   store_data,
    output logic              mem_stall,
    output logic              read_valid,
    output logic [XLEN-1:0]   read_data,
    output logic [XLEN-1:0]   wb_mask,
    output logic              misaligned,
    output logic              bus_err,
    output logic              dbus_req_valid,
    input  logic              dbus_req_ready,
    output logic [ADDR_W-1:0] dbus_addr,
    output logic              dbus_we,
    output logic [3:0]        dbus_wstrb,
    output logic [XLEN-1:0]   dbus_wdata,
    input  logic              dbus_resp_valid,
    input  logic              dbus_resp_err,
    input  logic [XLEN-1:0]   dbus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   dbus_addr_q, dbus_addr_d;
    logic                dbus_we_q, dbus_we_d;
    logic [3:0]          dbus_wstrb_q, dbus_wstrb_d;
    logic [XLEN-1:0]     dbus_wdata_q, dbus_wdata_d;
    logic [1:0]          off_q, off_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [XLEN-1:0]     read_data_q, read_data_d;
    logic [XLEN-1:0]     wb_mask_q, wb_mask_d;
    logic                read_valid_q, read_valid_d;
    logic                bus_err_q, bus_err_d;

    logic                mis_cond;
    logic                mem_op;
    logic [XLEN-1:0]     shifted;
    logic [XLEN-1:0]     fmt_data;
    logic [XLEN-1:0]     fmt_mask;

    always_comb begin
        mis_cond = ((funct3[1:0] == 2'b01) && addr[0]) ||
                   ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        mem_op   = instr_valid && (is_load || is_store);

        shifted  = dbus_rdata >> {off_q, 3'b000};
        fmt_mask = '1;
        case (funct3_q)
            3'b000:  fmt_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            3'b001:  fmt_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            3'b100: begin
                fmt_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
                fmt_mask = {{(XLEN-8){1'b0}}, 8'hFF};
            end
            3'b101: begin
                fmt_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
                fmt_mask = {{(XLEN-16){1'b0}}, 16'hFFFF};
            end
            default: fmt_data = shifted;
        endcase

        state_d        = state_q;
        dbus_addr_d    = dbus_addr_q;
        dbus_we_d      = dbus_we_q;
        dbus_wstrb_d   = dbus_wstrb_q;
        dbus_wdata_d   = dbus_wdata_q;
        off_d          = off_q;
        funct3_d       = funct3_q;
        read_data_d    = read_data_q;
        wb_mask_d      = wb_mask_q;
        read_valid_d   = 1'b0;
        bus_err_d      = 1'b0;
        mem_stall      = 1'b0;
        dbus_req_valid = 1'b0;
        misaligned     = 1'b0;

        case (state_q)
            IDLE: begin
                misaligned = mem_op && mis_cond;
                if (mem_op && !mis_cond) begin
                    mem_stall   = 1'b1;
                    state_d     = REQ;
                    dbus_addr_d = {addr[ADDR_W-1:2], 2'b00};
                    dbus_we_d   = is_store;
                    off_d       = addr[1:0];
                    funct3_d    = funct3;
                    case (funct3[1:0])
                        2'b00: begin
                            dbus_wstrb_d = 4'b0001 << addr[1:0];
                            dbus_wdata_d = {(XLEN/8){store_data[7:0]}};
                        end
                        2'b01: begin
                            dbus_wstrb_d = 4'b0011 << addr[1:0];
                            dbus_wdata_d = {(XLEN/16){store_data[15:0]}};
                        end
                        default: begin
                            dbus_wstrb_d = 4'b1111;
                            dbus_wdata_d = store_data;
                        end
                    endcase
                end
            end
            REQ: begin
                dbus_req_valid = 1'b1;
                mem_stall      = 1'b1;
                if (dbus_req_ready) state_d = RESP;
            end
            RESP: begin
                mem_stall = 1'b1;
                if (dbus_resp_valid) begin
                    state_d      = DONE;
                    bus_err_d    = dbus_resp_err;
                    read_valid_d = !dbus_we_q && !dbus_resp_err;
                    // Stores and errored loads leave the previous load result in place.
                    if (!dbus_we_q && !dbus_resp_err) begin
                        read_data_d = fmt_data;
                        wb_mask_d   = fmt_mask;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            dbus_addr_q  <= '0;
            dbus_we_q    <= 1'b0;
            dbus_wstrb_q <= '0;
            dbus_wdata_q <= '0;
            off_q        <= '0;
            funct3_q     <= '0;
            read_data_q  <= '0;
            wb_mask_q    <= '1;
            read_valid_q <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            dbus_addr_q  <= dbus_addr_d;
            dbus_we_q    <= dbus_we_d;
            dbus_wstrb_q <= dbus_wstrb_d;
            dbus_wdata_q <= dbus_wdata_d;
            off_q        <= off_d;
            funct3_q     <= funct3_d;
            read_data_q  <= read_data_d;
            wb_mask_q    <= wb_mask_d;
            read_valid_q <= read_valid_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign dbus_addr  = dbus_addr_q;
    assign dbus_we    = dbus_we_q;
    assign dbus_wstrb = dbus_wstrb_q;
    assign dbus_wdata = dbus_wdata_q;
    assign read_data  = read_data_q;
    assign wb_mask    = wb_mask_q;
    assign read_valid = read_valid_q;
    assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_access.sv
// Randomized bench for mem_access: each transaction is predicted from the
// access rules (sizes, offsets, extension) and checked cycle by cycle.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid, is_load, is_store;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic        mem_stall, read_valid, misaligned, bus_err;
    logic [31:0] read_data, wb_mask;
    logic        dbus_req_valid, dbus_req_ready, dbus_we;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
    logic [3:0]  dbus_wstrb;
    logic        dbus_resp_valid, dbus_resp_err;

    always #5 clk = ~clk;

    mem_access #(.ADDR_W(32), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .is_load(is_load),
        .is_store(is_store), .funct3(funct3), .addr(addr), .store_data(store_data),
        .mem_stall(mem_stall), .read_valid(read_valid), .read_data(read_data),
        .wb_mask(wb_mask), .misaligned(misaligned), .bus_err(bus_err),
        .dbus_req_valid(dbus_req_valid), .dbus_req_ready(dbus_req_ready),
        .dbus_addr(dbus_addr), .dbus_we(dbus_we), .dbus_wstrb(dbus_wstrb),
        .dbus_wdata(dbus_wdata), .dbus_resp_valid(dbus_resp_valid),
        .dbus_resp_err(dbus_resp_err), .dbus_rdata(dbus_rdata)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [31:0] exp_rd, exp_mask;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete instruction: IDLE, REQ for rdy_dly+1 cycles, RESP for rsp_dly cycles, DONE.
    task automatic run_access(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] sd, input int unsigned rdy_dly,
                              input int unsigned rsp_dly, input bit err, input logic [31:0] rdata);
        int unsigned off, sz;
        bit          mis;
        logic [31:0] sh, v, strb, wd;
        off  = a % 4;
        sz   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        mis  = (a % sz) != 0;
        strb = ((32'd1 << sz) - 1) << off;
        wd   = (sz == 1) ? (sd & 32'hFF) * 32'h0101_0101 :
               (sz == 2) ? (sd & 32'hFFFF) * 32'h0001_0001 : sd;

        @(negedge clk);
        instr_valid = 1'b1; is_load = ld; is_store = !ld;
        funct3 = f3; addr = a; store_data = sd;
        #1;
        check("rv_idle", read_valid, 0);
        check("berr_idle", bus_err, 0);
        check("misaligned", misaligned, mis);
        check("req_idle", dbus_req_valid, 0);
        if (mis) begin
            check("stall_mis", mem_stall, 0);
            @(negedge clk);
            instr_valid = 1'b0;
            #1;
            check("req_after_mis", dbus_req_valid, 0);
            check("stall_after_mis", mem_stall, 0);
            return;
        end
        check("stall_idle", mem_stall, 1);

        for (int k = 0; k <= int'(rdy_dly); k++) begin
            @(negedge clk);
            if (k == 0 && $urandom_range(1) == 1) instr_valid = 1'b0;
            dbus_req_ready  = (k == int'(rdy_dly));
            dbus_resp_valid = (k != int'(rdy_dly)) ? 1'($urandom_range(1)) : 1'b0;
            dbus_rdata      = $urandom;
            #1;
            check("req_valid", dbus_req_valid, 1);
            check("stall_req", mem_stall, 1);
            check("addr", dbus_addr, a & 32'hFFFF_FFFC);
            check("we", dbus_we, !ld);
            if (!ld) begin
                check("wstrb", dbus_wstrb, strb);
                check("wdata", dbus_wdata, wd);
            end
        end

        for (int k = 0; k < int'(rsp_dly); k++) begin
            @(negedge clk);
            instr_valid     = 1'b0;
            dbus_req_ready  = 1'b0;
            dbus_resp_valid = (k == int'(rsp_dly) - 1);
            dbus_resp_err   = err;
            dbus_rdata      = dbus_resp_valid ? rdata : $urandom;
            #1;
            check("req_resp", dbus_req_valid, 0);
            check("stall_resp", mem_stall, 1);
        end

        if (ld && !err) begin
            sh = rdata >> (8 * off);
            case (f3)
                3'd0: begin v = sh & 32'hFF;   if (v >= 128)   v = v - 256;   end
                3'd1: begin v = sh & 32'hFFFF; if (v >= 32768) v = v - 65536; end
                3'd4: v = sh & 32'hFF;
                3'd5: v = sh & 32'hFFFF;
                default: v = sh;
            endcase
            exp_rd   = v;
            exp_mask = (f3 == 3'd4) ? 32'hFF : (f3 == 3'd5) ? 32'hFFFF : 32'hFFFF_FFFF;
        end

        @(negedge clk);
        dbus_resp_valid = 1'b0; dbus_resp_err = 1'b0; instr_valid = 1'b0;
        #1;
        check("stall_done", mem_stall, 0);
        check("req_done", dbus_req_valid, 0);
        check("read_valid", read_valid, ld && !err);
        check("bus_err", bus_err, err);
        check("read_data", read_data, exp_rd);
        check("wb_mask", wb_mask, exp_mask);
    endtask

    task automatic reset_mid_resp();
        @(negedge clk);
        instr_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h100;
        @(negedge clk);
        instr_valid = 1'b0; dbus_req_ready = 1'b1;
        @(negedge clk);
        dbus_req_ready = 1'b0;
        #1;
        check("stall_pre_rst", mem_stall, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("req_post_rst", dbus_req_valid, 0);
        check("stall_post_rst", mem_stall, 0);
        dbus_resp_valid = 1'b1; dbus_rdata = 32'h5555_AAAA;
        @(negedge clk);
        dbus_resp_valid = 1'b0;
        #1;
        check("rv_stray", read_valid, 0);
        check("rd_stray", read_data, 0);
        exp_rd = '0; exp_mask = '1;
    endtask

    initial begin
        rst = 1'b1; instr_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
        funct3 = '0; addr = '0; store_data = '0;
        dbus_req_ready = 1'b0; dbus_resp_valid = 1'b0; dbus_resp_err = 1'b0; dbus_rdata = '0;
        exp_rd = '0; exp_mask = '1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_stall", mem_stall, 0);
        check("rst_req", dbus_req_valid, 0);
        check("rst_rv", read_valid, 0);
        check("rst_rd", read_data, 0);
        check("rst_mask", wb_mask, 32'hFFFF_FFFF);
        check("rst_berr", bus_err, 0);
        check("rst_addr", dbus_addr, 0);
        check("rst_wstrb", {28'd0, dbus_wstrb}, 0);

        run_access(1, 3'd2, 32'h100, 32'h0, 0, 1, 0, 32'hDEAD_BEEF);
        run_access(1, 3'd0, 32'h103, 32'h0, 0, 1, 0, 32'h80FF_FFFF);
        run_access(1, 3'd4, 32'h103, 32'h0, 0, 1, 0, 32'h80FF_FFFF);
        run_access(0, 3'd1, 32'h202, 32'h1234_ABCD, 3, 1, 0, 32'h0);
        run_access(1, 3'd2, 32'h101, 32'h0, 0, 1, 0, 32'h0);
        run_access(1, 3'd1, 32'h302, 32'h0, 1, 2, 1, 32'h1111_2222);
        run_access(1, 3'd5, 32'h302, 32'h0, 0, 1, 0, 32'h89AB_CDEF);
        reset_mid_resp();

        for (int i = 0; i < 200; i++) begin
            bit          ld;
            logic [2:0]  f3;
            ld = 1'($urandom_range(1));
            case ($urandom_range(4))
                0: f3 = 3'd0;
                1: f3 = 3'd1;
                2: f3 = 3'd2;
                3: f3 = ld ? 3'd4 : 3'd0;
                default: f3 = ld ? 3'd5 : 3'd1;
            endcase
            if ($urandom_range(7) == 0) begin
                @(negedge clk);
                instr_valid = 1'($urandom_range(1));
                is_load = 1'b0; is_store = 1'b0;
                #1;
                check("stall_nop", mem_stall, 0);
                check("mis_nop", misaligned, 0);
                instr_valid = 1'b0;
            end
            run_access(ld, f3, $urandom, $urandom, $urandom_range(3), $urandom_range(3, 1),
                       ($urandom_range(7) == 0), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
